// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg: sizing helpers and flag-threshold defaults shared by the AXI-Stream FIFO.
package axis_fifo_pkg;
    localparam int AFULL_MARGIN   = 2;
    localparam int AEMPTY_DEFAULT = 2;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int addr_w(input int depth);
        return clog2(depth);
    endfunction
    function automatic int count_w(input int depth);
        return clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fifo_ram_2p.sv
// fifo_ram_2p: simple dual-port storage, synchronous write and asynchronous read.
module fifo_ram_2p #(
    parameter int W     = 129,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];
    always_ff @(posedge clock) if (we) mem_q[waddr] <= wdata;
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/axis_fifo_param.sv
// axis_fifo_param: parametrised FWFT AXI-Stream FIFO with level and threshold flags.
// Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward packet mode.
module axis_fifo_param
    import axis_fifo_pkg::*;
#(
    parameter int DATA_W        = 128,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = DEPTH - AFULL_MARGIN,
    parameter int AEMPTY_THRESH = AEMPTY_DEFAULT,
    localparam int AW = addr_w(DEPTH),
    localparam int CW = count_w(DEPTH)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [CW-1:0]     level,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty
);
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q, level_d;
    logic          push, pop;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          push_last, pop_last;
`endif

    fifo_ram_2p #(.W(DATA_W + 1), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({s_tlast, s_tdata}),
        .raddr (rd_ptr_q),
        .rdata ({m_tlast, m_tdata})
    );

    always_comb begin
        level        = level_q;
        full         = level_q == CW'(DEPTH);
        empty        = level_q == '0;
        almost_full  = level_q >= CW'(AFULL_THRESH);
        almost_empty = level_q <= CW'(AEMPTY_THRESH);
        s_tready     = !full;
`ifdef AXIS_FIFO_PACKET_MODE_EN
        // full override lets packets longer than DEPTH drain cut-through
        m_tvalid     = !empty && (pkt_cnt_q != '0 || full);
`else
        m_tvalid     = !empty;
`endif
        push         = s_tvalid && s_tready;
        pop          = m_tvalid && m_tready;
        wr_ptr_d     = !rst ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d     = !rst ? '0 : rd_ptr_q + AW'(pop);
        level_d      = !rst ? '0
                     : (push && !pop) ? level_q + 1'b1
                     : (pop && !push) ? level_q - 1'b1
                     : level_q;
`ifdef AXIS_FIFO_PACKET_MODE_EN
        push_last    = push && s_tlast;
        pop_last     = pop && m_tlast;
        pkt_cnt_d    = !rst ? '0
                     : (push_last && !pop_last) ? pkt_cnt_q + 1'b1
                     : (pop_last && !push_last) ? pkt_cnt_q - 1'b1
                     : pkt_cnt_q;
`endif
    end

    always_ff @(posedge clock) begin
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        level_q   <= level_d;
`ifdef AXIS_FIFO_PACKET_MODE_EN
        pkt_cnt_q <= pkt_cnt_d;
`endif
    end
endmodule

// File: tb/tb_axis_fifo_param.sv
// tb_axis_fifo_param: table-driven directed check of axis_fifo_param (DATA_W=128, DEPTH=8).
module tb_axis_fifo_param;
    localparam int W = 128;

    logic         clock = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] s_tdata = '0;
    logic         s_tlast = 1'b0, s_tvalid = 1'b0, m_tready = 1'b0;
    logic [W-1:0] m_tdata;
    logic         s_tready, m_tlast, m_tvalid;
    logic [3:0]   level;
    logic         full, empty, almost_full, almost_empty;
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        string        name;
        logic         rn, sv, sl, mr;
        logic [W-1:0] sd;
        logic [3:0]   lvl;
        logic         mv;
        logic [W-1:0] hd;
        logic         hl;
    } vec_t;
    vec_t vecs[$];

    always #5 clock = ~clock;

    axis_fifo_param #(.DATA_W(W), .DEPTH(8)) dut (
        .clock        (clock),
        .rst          (rst),
        .s_tdata      (s_tdata),
        .s_tlast      (s_tlast),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    function automatic logic [W-1:0] dw(input int n);
        return {4{32'hD000_0000 | 32'(n)}};
    endfunction

    function automatic logic lw(input int n);
        return n % 4 == 3;
    endfunction

    function automatic void add(input string name, input logic rn, input logic sv, input logic sl,
                                input logic [W-1:0] sd, input logic mr, input int lvl,
                                input logic mv, input logic [W-1:0] hd, input logic hl);
        vec_t v;
        v.name = name; v.rn = rn; v.sv = sv; v.sl = sl; v.mr = mr; v.sd = sd;
        v.lvl = 4'(lvl); v.mv = mv; v.hd = hd; v.hl = hl;
        vecs.push_back(v);
    endfunction

    // Each vector: drive inputs, take one clock edge, compare the state left behind.
    task automatic run();
        logic [9:0] exp_s, got_s;
        foreach (vecs[i]) begin
            rst = vecs[i].rn; s_tvalid = vecs[i].sv; s_tlast = vecs[i].sl;
            s_tdata = vecs[i].sd; m_tready = vecs[i].mr;
            @(posedge clock);
            #1;
            exp_s = {vecs[i].lvl, vecs[i].lvl == 4'd8, vecs[i].lvl == 4'd0, vecs[i].lvl >= 4'd6,
                     vecs[i].lvl <= 4'd2, vecs[i].lvl != 4'd8, vecs[i].mv};
            got_s = {level, full, empty, almost_full, almost_empty, s_tready, m_tvalid};
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL %s[%0d] status {level,full,empty,afull,aempty,s_tready,m_tvalid} got=%b expected=%b",
                         vecs[i].name, i, got_s, exp_s);
            end
            if (vecs[i].mv) begin
                checks++;
                if ({m_tlast, m_tdata} !== {vecs[i].hl, vecs[i].hd}) begin
                    errors++;
                    $display("FAIL %s[%0d] head {tlast,tdata} got=%h expected=%h",
                             vecs[i].name, i, {m_tlast, m_tdata}, {vecs[i].hl, vecs[i].hd});
                end
            end
        end
        vecs.delete();
    endtask

    initial begin
        add("reset", 0, 0, 0, '0, 0, 0, 0, '0, 0);
`ifndef AXIS_FIFO_PACKET_MODE_EN
        for (int i = 0; i < 8; i++) add("fill", 1, 1, lw(i), dw(i), 0, i + 1, 1, dw(0), lw(0));
        add("overflow", 1, 1, 0, dw(99), 0, 8, 1, dw(0), lw(0));
        for (int i = 0; i < 8; i++) add("drain", 1, 0, 0, '0, 1, 7 - i, i < 7, dw(i + 1), lw(i + 1));
        for (int i = 0; i < 4; i++) add("prefill", 1, 1, lw(20 + i), dw(20 + i), 0, i + 1, 1, dw(20), lw(20));
        for (int i = 0; i < 20; i++) add("stream", 1, 1, lw(24 + i), dw(24 + i), 1, 4, 1, dw(21 + i), lw(21 + i));
        for (int i = 0; i < 4; i++) add("flush", 1, 0, 0, '0, 1, 3 - i, i < 3, dw(41 + i), lw(41 + i));
        add("fwft_push", 1, 1, 1, {16{8'hA5}}, 1, 1, 1, {16{8'hA5}}, 1);
        add("fwft_pop", 1, 0, 0, '0, 1, 0, 0, '0, 0);
        for (int i = 0; i < 5; i++) add("level5", 1, 1, lw(50 + i), dw(50 + i), 0, i + 1, 1, dw(50), lw(50));
        add("mid_rst", 0, 1, 0, dw(60), 1, 0, 0, '0, 0);
        add("post_rst", 1, 0, 0, '0, 1, 0, 0, '0, 0);
        add("restart", 1, 1, lw(61), dw(61), 0, 1, 1, dw(61), lw(61));
`else
        for (int i = 0; i < 3; i++) add("pkt_open", 1, 1, 0, dw(i), 1, i + 1, 0, '0, 0);
        add("pkt_close", 1, 1, 1, dw(3), 1, 4, 1, dw(0), 0);
        for (int k = 0; k < 4; k++) add("pkt_drain", 1, 0, 0, '0, 1, 3 - k, k < 3, dw(1 + k), k == 2);
        for (int i = 0; i < 8; i++) add("long_fill", 1, 1, 0, dw(100 + i), 1, i + 1, i == 7, dw(100), 0);
        add("long_pop_full", 1, 1, 0, dw(108), 1, 7, 0, '0, 0);
        add("long_refill", 1, 1, 0, dw(108), 1, 8, 1, dw(101), 0);
        add("long_pop_full2", 1, 1, 1, dw(109), 1, 7, 0, '0, 0);
        add("long_last", 1, 1, 1, dw(109), 1, 8, 1, dw(102), 0);
        for (int k = 0; k < 8; k++) add("long_drain", 1, 0, 0, '0, 1, 7 - k, k < 7, dw(103 + k), k == 6);
`endif
        run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
